// File: rtl/axil_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_uart_pkg
//  Description : Shared definitions for the AXI4-Lite UART register block:
//                register word indices, AXI response codes and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_uart_pkg;

    // Register word indices, decoded from ADDR[3:2]
    localparam logic [1:0] RXDATA_OFF  = 2'd0;
    localparam logic [1:0] TXDATA_OFF  = 2'd1;
    localparam logic [1:0] STATUS_OFF  = 2'd2;
    localparam logic [1:0] CTRL_OFF    = 2'd3;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_uart_regs_if.sv
`default_nettype none
// ============================================================================
//  Module      : axil_uart_regs_if
//  Description : AXI4-Lite bus bundle between the interconnect (master) and
//                the UART register block (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface axil_uart_regs_if #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;
    logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;
    logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;
    logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface
`default_nettype wire

// File: rtl/axil_uart_regs.sv
`default_nettype none
// ============================================================================
//  Module      : axil_uart_regs
//  Description : AXI4-Lite slave owning the host side of the UART byte
//                interface: RX pop, TX push, status and enable control.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_uart_regs
    import axil_uart_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  wire logic        Clk,
    input  wire logic        Resetn,
    axil_uart_regs_if.slave  s_axi,
    input  wire logic [7:0]  RX_data,
    input  wire logic        Empty,
    input  wire logic        Full,
    output logic             rd_uart_en,
    output logic [7:0]       TX_data,
    output logic             wr_uart_en,
    output logic             Enable_rx,
    output logic             Enable_tx
);

    wr_state_t   wr_state_q, wr_state_d;
    rd_state_t   rd_state_q, rd_state_d;
    logic [1:0]  bresp_q,    bresp_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        wr_en_q,    wr_en_d;
    logic [1:0]  ctrl_q,     ctrl_d;     // bit0 = rx enable, bit1 = tx enable
    logic [31:0] rdata_q,    rdata_d;
    logic        rd_en_q,    rd_en_d;

    logic        w_aw_w_valid;
    logic [1:0]  w_wr_idx;
    logic [1:0]  w_rd_idx;

    assign w_aw_w_valid = s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    assign w_wr_idx     = s_axi.S_AXI_AWADDR[3:2];
    assign w_rd_idx     = s_axi.S_AXI_ARADDR[3:2];

    // Write channel: accept AW+W together, act on the handshake edge, then hold the response
    always_comb begin
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        tx_data_d  = tx_data_q;
        wr_en_d    = 1'b0;
        ctrl_d     = ctrl_q;
        case (wr_state_q)
            W_IDLE: begin
                if (w_aw_w_valid) wr_state_d = W_ACK;
            end
            W_ACK: begin
                if (w_aw_w_valid) begin
                    wr_state_d = W_RESP;
                    bresp_d    = RESP_OKAY;
                    case (w_wr_idx)
                        TXDATA_OFF: begin
                            // A full TX FIFO rejects the byte outright
                            if (Full) begin
                                bresp_d = RESP_SLVERR;
                            end else if (s_axi.S_AXI_WSTRB[0]) begin
                                tx_data_d = s_axi.S_AXI_WDATA[7:0];
                                wr_en_d   = 1'b1;
                            end
                        end
                        CTRL_OFF: begin
                            if (s_axi.S_AXI_WSTRB[0]) ctrl_d = s_axi.S_AXI_WDATA[1:0];
                        end
                        default: ;  // RXDATA / STATUS are read-only
                    endcase
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read channel: capture data in the address-ack cycle, then hold until taken
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rd_en_d    = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (s_axi.S_AXI_ARVALID) rd_state_d = R_ACK;
            end
            R_ACK: begin
                if (s_axi.S_AXI_ARVALID) begin
                    rd_state_d = R_DATA;
                    case (w_rd_idx)
                        RXDATA_OFF: begin
                            // Pop only when a byte is actually present; bit 8 flags it
                            if (!Empty) begin
                                rdata_d = {23'b0, 1'b1, RX_data};
                                rd_en_d = 1'b1;
                            end else begin
                                rdata_d = 32'h0;
                            end
                        end
                        STATUS_OFF: rdata_d = {30'b0, Full, Empty};
                        CTRL_OFF:   rdata_d = {30'b0, ctrl_q};
                        default:    rdata_d = 32'h0;   // TXDATA is write-only
                    endcase
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            bresp_q    <= RESP_OKAY;
            tx_data_q  <= 8'h00;
            wr_en_q    <= 1'b0;
            ctrl_q     <= 2'b00;
            rdata_q    <= 32'h0;
            rd_en_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            bresp_q    <= bresp_d;
            tx_data_q  <= tx_data_d;
            wr_en_q    <= wr_en_d;
            ctrl_q     <= ctrl_d;
            rdata_q    <= rdata_d;
            rd_en_q    <= rd_en_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = (wr_state_q == W_ACK);
    assign s_axi.S_AXI_WREADY  = (wr_state_q == W_ACK);
    assign s_axi.S_AXI_BVALID  = (wr_state_q == W_RESP);
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = (rd_state_q == R_ACK);
    assign s_axi.S_AXI_RVALID  = (rd_state_q == R_DATA);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    assign TX_data    = tx_data_q;
    assign wr_uart_en = wr_en_q;
    assign rd_uart_en = rd_en_q;
    assign Enable_rx  = ctrl_q[0];
    assign Enable_tx  = ctrl_q[1];

    // Address low bits, upper data lanes and upper strobes carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR,
                           s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB};

endmodule
`default_nettype wire

// File: tb/tb_axil_uart_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_uart_regs
//  Description : Self-checking bench for axil_uart_regs: directed table,
//                randomized operations against a register-level model, and
//                hand-written concurrency / reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_uart_regs;
    import axil_uart_pkg::*;

    logic       Clk = 1'b0;
    logic       Resetn = 1'b0;
    logic [7:0] RX_data = 8'h00;
    logic       Empty = 1'b1;
    logic       Full = 1'b0;
    logic       rd_uart_en;
    logic [7:0] TX_data;
    logic       wr_uart_en;
    logic       Enable_rx;
    logic       Enable_tx;

    axil_uart_regs_if #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) bus ();

    axil_uart_regs #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
        .Clk        (Clk),
        .Resetn     (Resetn),
        .s_axi      (bus),
        .RX_data    (RX_data),
        .Empty      (Empty),
        .Full       (Full),
        .rd_uart_en (rd_uart_en),
        .TX_data    (TX_data),
        .wr_uart_en (wr_uart_en),
        .Enable_rx  (Enable_rx),
        .Enable_tx  (Enable_tx)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;

    // Pulse counters sampled mid-cycle
    always @(negedge Clk) begin
        if (wr_uart_en) push_cnt++;
        if (rd_uart_en) pop_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_rd;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          full;
        bit          empty;
        logic [7:0]  rxd;
        int          dly;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_pulses;
        logic [1:0]  exp_en;     // {Enable_tx, Enable_rx}
        logic [7:0]  exp_tx;
    } vec_t;

    // One write: AW+W in cycle N, READYs in N+1, BVALID in N+2, BREADY after dly cycles
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int dly, input logic [1:0] exp_resp, input string tag,
                             output int pushes);
        int p0;
        p0 = push_cnt;
        @(posedge Clk); #1;
        bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
        @(posedge Clk); #1;
        chk({tag, ".awready"}, {31'b0, bus.S_AXI_AWREADY & bus.S_AXI_WREADY}, 32'd1);
        @(posedge Clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        chk({tag, ".bvalid"}, {31'b0, bus.S_AXI_BVALID}, 32'd1);
        chk({tag, ".bresp"}, {30'b0, bus.S_AXI_BRESP}, {30'b0, exp_resp});
        for (int i = 0; i < dly; i++) begin
            @(posedge Clk); #1;
            chk({tag, ".bhold"}, {29'b0, bus.S_AXI_BVALID, bus.S_AXI_BRESP}, {29'b0, 1'b1, exp_resp});
        end
        bus.S_AXI_BREADY = 1'b1;
        @(posedge Clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        chk({tag, ".bdrop"}, {31'b0, bus.S_AXI_BVALID}, 32'd0);
        @(negedge Clk);
        pushes = push_cnt - p0;
    endtask

    // One read: AR in cycle N, ARREADY in N+1, RVALID/RDATA in N+2, RREADY after dly cycles
    task automatic axi_read(input logic [3:0] addr, input int dly, input logic [31:0] exp_data,
                            input string tag, output int pops);
        int p0;
        p0 = pop_cnt;
        @(posedge Clk); #1;
        bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
        @(posedge Clk); #1;
        chk({tag, ".arready"}, {31'b0, bus.S_AXI_ARREADY}, 32'd1);
        @(posedge Clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
        chk({tag, ".rvalid"}, {31'b0, bus.S_AXI_RVALID}, 32'd1);
        chk({tag, ".rdata"}, bus.S_AXI_RDATA, exp_data);
        chk({tag, ".rresp"}, {30'b0, bus.S_AXI_RRESP}, {30'b0, RESP_OKAY});
        for (int i = 0; i < dly; i++) begin
            @(posedge Clk); #1;
            chk({tag, ".rhold"}, bus.S_AXI_RDATA, exp_data);
        end
        bus.S_AXI_RREADY = 1'b1;
        @(posedge Clk); #1;
        bus.S_AXI_RREADY = 1'b0;
        chk({tag, ".rdrop"}, {31'b0, bus.S_AXI_RVALID}, 32'd0);
        @(negedge Clk);
        pops = pop_cnt - p0;
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int n;
        Full = v.full; Empty = v.empty; RX_data = v.rxd;
        if (v.is_rd) begin
            axi_read(v.addr, v.dly, v.exp_rdata, tag, n);
            chk({tag, ".pops"}, n, v.exp_pulses);
        end else begin
            axi_write(v.addr, v.wdata, v.strb, v.dly, v.exp_resp, tag, n);
            chk({tag, ".pushes"}, n, v.exp_pulses);
        end
        chk({tag, ".en"}, {30'b0, Enable_tx, Enable_rx}, {30'b0, v.exp_en});
        chk({tag, ".tx"}, {24'b0, TX_data}, {24'b0, v.exp_tx});
    endtask

    vec_t        tbl[14];
    vec_t        rv;
    logic [1:0]  m_en;
    logic [7:0]  m_tx;
    int          p_before, p_after, n_w, n_r;

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
        bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;  bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;

        //            rd  addr   wdata         strb  F  E  rxd    dly resp         rdata         p  en     tx
        tbl[0]  = '{1'b1, 4'hC, 32'h0,        4'h0, 0, 1, 8'h00, 0, RESP_OKAY,   32'h0,        0, 2'b00, 8'h00};
        tbl[1]  = '{1'b0, 4'hC, 32'h3,        4'hF, 0, 1, 8'h00, 2, RESP_OKAY,   32'h0,        0, 2'b11, 8'h00};
        tbl[2]  = '{1'b1, 4'hC, 32'h0,        4'h0, 0, 1, 8'h00, 0, RESP_OKAY,   32'h3,        0, 2'b11, 8'h00};
        tbl[3]  = '{1'b0, 4'h4, 32'hA5,       4'h1, 0, 1, 8'h00, 0, RESP_OKAY,   32'h0,        1, 2'b11, 8'hA5};
        tbl[4]  = '{1'b0, 4'h4, 32'h5A,       4'h1, 1, 1, 8'h00, 1, RESP_SLVERR, 32'h0,        0, 2'b11, 8'hA5};
        tbl[5]  = '{1'b1, 4'h0, 32'h0,        4'h0, 0, 0, 8'h3C, 5, RESP_OKAY,   32'h13C,      1, 2'b11, 8'hA5};
        tbl[6]  = '{1'b1, 4'h0, 32'h0,        4'h0, 0, 1, 8'h3C, 1, RESP_OKAY,   32'h0,        0, 2'b11, 8'hA5};
        tbl[7]  = '{1'b0, 4'h4, 32'hFF,       4'hE, 0, 1, 8'h00, 0, RESP_OKAY,   32'h0,        0, 2'b11, 8'hA5};
        tbl[8]  = '{1'b0, 4'hC, 32'h0,        4'hE, 0, 1, 8'h00, 0, RESP_OKAY,   32'h0,        0, 2'b11, 8'hA5};
        tbl[9]  = '{1'b0, 4'hF, 32'hFFFF_FFF2, 4'h1, 0, 1, 8'h00, 3, RESP_OKAY,  32'h0,        0, 2'b10, 8'hA5};
        tbl[10] = '{1'b1, 4'hD, 32'h0,        4'h0, 0, 1, 8'h00, 0, RESP_OKAY,   32'h2,        0, 2'b10, 8'hA5};
        tbl[11] = '{1'b1, 4'h8, 32'h0,        4'h0, 1, 0, 8'h00, 0, RESP_OKAY,   32'h2,        0, 2'b10, 8'hA5};
        tbl[12] = '{1'b1, 4'hA, 32'h0,        4'h0, 0, 1, 8'h00, 2, RESP_OKAY,   32'h1,        0, 2'b10, 8'hA5};
        tbl[13] = '{1'b0, 4'h0, 32'hFF,       4'hF, 0, 0, 8'h77, 0, RESP_OKAY,   32'h0,        0, 2'b10, 8'hA5};

        // Reset values
        repeat (3) @(posedge Clk);
        #1;
        chk("rst.handshake", {26'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                              bus.S_AXI_ARREADY, bus.S_AXI_RVALID, 1'b0}, 32'h0);
        chk("rst.resp", {28'b0, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 32'h0);
        chk("rst.rdata", bus.S_AXI_RDATA, 32'h0);
        chk("rst.uart", {20'b0, TX_data, wr_uart_en, rd_uart_en, Enable_tx, Enable_rx}, 32'h0);
        @(negedge Clk);
        Resetn = 1'b1;

        // A lone AWVALID must not be accepted
        @(posedge Clk); #1;
        bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            chk("lone_aw.awready", {31'b0, bus.S_AXI_AWREADY}, 32'd0);
        end
        bus.S_AXI_AWVALID = 1'b0;
        @(posedge Clk); #1;

        // Directed table
        for (int i = 0; i < 14; i++) do_op(tbl[i], $sformatf("tbl%0d", i));

        // Randomized operations against a register-level model
        m_en = tbl[13].exp_en;
        m_tx = tbl[13].exp_tx;
        for (int i = 0; i < 150; i++) begin
            rv.is_rd = 1'($urandom_range(0, 1));
            rv.addr  = 4'($urandom_range(0, 15));
            rv.wdata = $urandom;
            rv.strb  = 4'($urandom_range(0, 15));
            rv.full  = 1'($urandom_range(0, 1));
            rv.empty = 1'($urandom_range(0, 1));
            rv.rxd   = 8'($urandom);
            rv.dly   = $urandom_range(0, 3);
            if (!rv.is_rd && rv.addr[3:2] == 2'd1 && !rv.strb[0]) rv.full = 1'b0;
            rv.exp_resp   = RESP_OKAY;
            rv.exp_rdata  = 32'h0;
            rv.exp_pulses = 0;
            if (rv.is_rd) begin
                case (rv.addr[3:2])
                    2'd0: if (!rv.empty) begin
                              rv.exp_rdata  = 32'h100 + rv.rxd;
                              rv.exp_pulses = 1;
                          end
                    2'd2: rv.exp_rdata = (rv.full ? 32'd2 : 32'd0) + (rv.empty ? 32'd1 : 32'd0);
                    2'd3: rv.exp_rdata = {30'b0, m_en};
                    default: rv.exp_rdata = 32'h0;
                endcase
            end else begin
                case (rv.addr[3:2])
                    2'd1: if (rv.full) rv.exp_resp = RESP_SLVERR;
                          else if (rv.strb[0]) begin
                              rv.exp_pulses = 1;
                              m_tx = rv.wdata[7:0];
                          end
                    2'd3: if (rv.strb[0]) m_en = rv.wdata[1:0];
                    default: ;
                endcase
            end
            rv.exp_en = m_en;
            rv.exp_tx = m_tx;
            do_op(rv, $sformatf("rnd%0d", i));
        end

        // Concurrent TXDATA write and STATUS read
        Full = 1'b0; Empty = 1'b0;
        fork
            axi_write(4'h4, 32'h66, 4'h1, 1, RESP_OKAY, "conc.w", n_w);
            axi_read(4'h8, 0, 32'h0, "conc.r", n_r);
        join
        chk("conc.pushes", n_w, 1);
        chk("conc.pops", n_r, 0);
        chk("conc.tx", {24'b0, TX_data}, 32'h66);

        // Reset while BVALID is pending
        axi_write(4'hC, 32'h3, 4'h1, 0, RESP_OKAY, "prerst", n_w);
        chk("prerst.en", {30'b0, Enable_tx, Enable_rx}, 32'h3);
        p_before = push_cnt;
        @(posedge Clk); #1;
        bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = 32'h99; bus.S_AXI_WSTRB = 4'h1;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        @(posedge Clk); #2;
        chk("midrst.bvalid_before", {31'b0, bus.S_AXI_BVALID}, 32'd1);
        chk("midrst.push_before", push_cnt - p_before, 1);
        Resetn = 1'b0;
        #1;
        chk("midrst.bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd0);
        chk("midrst.en", {30'b0, Enable_tx, Enable_rx}, 32'h0);
        chk("midrst.tx", {23'b0, TX_data, wr_uart_en}, 32'h0);
        p_after = push_cnt;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Resetn = 1'b1;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        chk("midrst.no_push", push_cnt - p_after, 0);
        axi_read(4'hC, 0, 32'h0, "postrst.ctrl", n_r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #500000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
